// File: rtl/j1_io_uart.sv
// J1 CPU memory-mapped I/O block: 8N1 UART with a small TX FIFO, LED register
// and a free-running 16-bit tick counter.
module j1_io_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [7:0]  leds
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH   = CW'(TX_DEPTH);

    localparam logic [15:0] ADDR_DATA   = 16'h1000;
    localparam logic [15:0] ADDR_STATUS = 16'h2000;
    localparam logic [15:0] ADDR_LEDS   = 16'h4000;
    localparam logic [15:0] ADDR_TICKS  = 16'h8000;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t       tx_state_q, tx_state_d;
    logic [15:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;

    rx_state_t       rx_state_q, rx_state_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_s1_q, rx_s2_q;
    logic            rx_done;

    logic [7:0]      fifo_q [TX_DEPTH];
    logic [7:0]      fifo_d [TX_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [7:0]      leds_q, leds_d;
    logic [15:0]     ticks_q, ticks_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_overrun_q, rx_overrun_d;

    logic rd_data, wr_data, wr_leds, wr_ticks;
    logic push, pop, tx_busy, tx_not_full;
    logic unused_dout;

    assign unused_dout = ^dout[15:8];

    assign rd_data  = io_rd && (mem_addr == ADDR_DATA);
    assign wr_data  = io_wr && (mem_addr == ADDR_DATA);
    assign wr_leds  = io_wr && (mem_addr == ADDR_LEDS);
    assign wr_ticks = io_wr && (mem_addr == ADDR_TICKS);

    assign tx_not_full = (count_q < DEPTH);
    assign tx_busy     = (tx_state_q != TX_IDLE);
    // A full FIFO drops the write even when the transmitter pops this cycle.
    assign push        = wr_data && tx_not_full;
    assign pop         = (tx_state_q == TX_IDLE) && (count_q != '0);
    assign leds        = leds_q;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = dout[7:0];
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (pop) begin
                    tx_shift_d = fifo_q[rd_ptr_q];
                    tx_cnt_d   = BIT_LAST;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = BIT_LAST;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else tx_cnt_d = tx_cnt_q - 1'b1;
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = BIT_LAST;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else tx_cnt_d = tx_cnt_q - 1'b1;
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
                else tx_cnt_d = tx_cnt_q - 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_q)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_q[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_cnt_d   = HALF_LAST;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // Line back high at mid-start: treat as a glitch.
                    if (rx_s2_q) rx_state_d = RX_IDLE;
                    else begin
                        rx_cnt_d   = BIT_LAST;
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end else rx_cnt_d = rx_cnt_q - 1'b1;
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = BIT_LAST;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else rx_cnt_d = rx_cnt_q - 1'b1;
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else rx_state_d = RX_WAIT;
                end else rx_cnt_d = rx_cnt_q - 1'b1;
            end
            RX_WAIT: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        leds_d       = leds_q;
        ticks_d      = ticks_q + 16'd1;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (wr_leds)  leds_d  = dout[7:0];
        if (wr_ticks) ticks_d = 16'h0000;
        if (rd_data) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end
        if (rx_done) begin
            if (rx_valid_q && !rd_data) rx_overrun_d = 1'b1;
            else begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        io_din = 16'h0000;
        if (io_rd) begin
            case (mem_addr)
                ADDR_DATA:   io_din = {8'h00, rx_byte_q};
                ADDR_STATUS: io_din = {12'h000, tx_busy, rx_overrun_q, rx_valid_q, tx_not_full};
                ADDR_LEDS:   io_din = {8'h00, leds_q};
                ADDR_TICKS:  io_din = ticks_q;
                default:     io_din = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            leds_q       <= '0;
            ticks_q      <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            leds_q       <= leds_d;
            ticks_q      <= ticks_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end
endmodule

// File: tb/tb_j1_io_uart.sv
// Directed self-checking bench for j1_io_uart with CLKS_PER_BIT=4, TX_DEPTH=4.
module tb_j1_io_uart;
    logic        clk;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic        uart_rx;
    logic        uart_tx;
    logic [7:0]  leds;

    int n_checks = 0;
    int n_errors = 0;
    int w;
    int lows;
    logic [15:0] v;

    j1_io_uart #(.CLKS_PER_BIT(4), .TX_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // All tasks are entered 1 time unit after a rising edge and return likewise.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_wr = 1'b1; mem_addr = a; dout = d;
        @(posedge clk); #1;
        io_wr = 1'b0; mem_addr = 16'h0000; dout = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] val);
        io_rd = 1'b1; mem_addr = a;
        #1 val = io_din;
        @(posedge clk); #1;
        io_rd = 1'b0; mem_addr = 16'h0000;
    endtask

    // Waits for a start bit, then checks every cycle of the 40-cycle frame.
    task automatic check_frame(input logic [7:0] b, input bit chk_busy, output int waited);
        logic exp_bit;
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 3 && chk_busy) begin
                io_rd = 1'b0; mem_addr = 16'h0000;
            end
            if (i < 4)       exp_bit = 1'b0;
            else if (i < 36) exp_bit = b[(i - 4) / 4];
            else             exp_bit = 1'b1;
            chk($sformatf("tx_%02h_cyc%0d", b, i), {15'd0, uart_tx}, {15'd0, exp_bit});
            if (i == 2 && chk_busy) begin
                io_rd = 1'b1; mem_addr = 16'h2000;
                #1 chk("tx_busy_in_frame", io_din & 16'h0008, 16'h0008);
            end
            if (i < 39) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic watch_idle(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
        mem_addr = 16'h0000; dout = 16'h0000; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_uart_tx", {15'd0, uart_tx}, 16'h0001);
        chk("rst_leds", {8'd0, leds}, 16'h0000);
        rd(16'h8000, v); chk("rst_ticks", v, 16'h0000);
        rd(16'h2000, v); chk("rst_status", v, 16'h0001);
        rd(16'h1000, v); chk("rst_data", v, 16'h0000);
        rd(16'h0000, v); chk("unmapped_0000", v, 16'h0000);
        mem_addr = 16'h8000;
        #1 chk("no_rd_zero", io_din, 16'h0000);
        mem_addr = 16'h0000;

        // LEDS, TICKS, STATUS write
        wr(16'h4000, 16'h01FF);
        chk("leds_out", {8'd0, leds}, 16'h00FF);
        rd(16'h4000, v); chk("leds_rd", v, 16'h00FF);
        rd(16'h4001, v); chk("unmapped_4001", v, 16'h0000);
        wr(16'h8000, 16'h1234);
        repeat (5) @(posedge clk);
        #1 rd(16'h8000, v); chk("ticks_5", v, 16'h0005);
        wr(16'h2000, 16'hFFFF);
        rd(16'h2000, v); chk("status_wr_ignored", v, 16'h0001);

        // Single frame 0xA5
        wr(16'h1000, 16'h00A5);
        check_frame(8'hA5, 1'b1, w);
        repeat (2) @(posedge clk);
        #1 rd(16'h2000, v); chk("status_after_a5", v, 16'h0001);

        // Six back-to-back writes into a 4-deep FIFO
        fork
            begin
                for (int k = 1; k <= 6; k++) wr(16'h1000, 16'(k));
                rd(16'h2000, v); chk("status_full", v, 16'h0008);
            end
            begin
                for (int k = 1; k <= 5; k++) begin
                    check_frame(8'(k), 1'b0, w);
                    if (k > 1) chk($sformatf("idle_gap_%0d", k), 16'(w), 16'd2);
                end
            end
        join
        watch_idle(60, lows);
        chk("no_sixth_frame", 16'(lows), 16'd0);
        rd(16'h2000, v); chk("status_drained", v, 16'h0001);

        // Framing error: byte discarded, flags unchanged, receiver recovers
        send_rx(8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #1 rd(16'h2000, v); chk("status_framing_err", v, 16'h0001);

        // Start-bit glitch shorter than half a bit
        uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (60) @(posedge clk);
        #1 rd(16'h2000, v); chk("status_glitch", v, 16'h0001);

        // One received byte; bit0 stays set because the TX FIFO is empty
        send_rx(8'h3C, 1'b1);
        repeat (4) @(posedge clk);
        #1 rd(16'h2000, v); chk("status_rx_valid", v, 16'h0003);
        rd(16'h1000, v); chk("data_3c", v, 16'h003C);
        rd(16'h2000, v); chk("status_rx_cleared", v, 16'h0001);

        // Overrun: second byte discarded, first kept
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1 rd(16'h2000, v); chk("status_overrun", v, 16'h0007);
        rd(16'h1000, v); chk("data_11", v, 16'h0011);
        rd(16'h2000, v); chk("status_ovr_cleared", v, 16'h0001);

        // Reset during data bit 3 of a 0xA5 frame
        wr(16'h1000, 16'h00A5);
        w = 0;
        while (uart_tx !== 1'b0 && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rst_frame_started", {15'd0, uart_tx}, 16'h0000);
        repeat (17) @(posedge clk);
        #1 chk("in_bit3", {15'd0, uart_tx}, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_tx_high", {15'd0, uart_tx}, 16'h0001);
        chk("abort_leds", {8'd0, leds}, 16'h0000);
        rd(16'h2000, v); chk("abort_status", v, 16'h0001);
        watch_idle(60, lows);
        chk("abort_quiet", 16'(lows), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
